switch_debouncer: RTL and testbench

- Conditions the raw DIP-switch banks before they reach the segment decoder and LED adder.
- Runs on the HSOSC-derived system clock. The two-digit display path then sees only clean, metastability-free switch values.
- Each bit has a two-flop synchronizer and its own stability counter.
- A debounced bit changes only after the synchronized input has held a new value for STABLE_CYCLES consecutive clocks.
- A one-cycle change strobe per bit flags each accepted transition.

---
 rtl/switch_debouncer.sv | 72 +++++++
 tb/tb_switch_debouncer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Per-bit switch debouncer: two-flop synchronizer followed by a stability counter per bit.
// A debounced bit changes only after its synchronized input holds a new level for STABLE_CYCLES clocks.
module switch_debouncer #(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned STABLE_CYCLES = 240000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_changed,
   output logic             any_changed
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] sw_db_q, sw_db_d;
   logic [WIDTH-1:0] sw_changed_q, sw_changed_d;
   logic             any_changed_q, any_changed_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // Next-state: synchronizer shift plus independent per-bit qualification.
   always_comb begin
      sync1_d      = sw_raw;
      sync2_d      = sync1_q;
      sw_db_d      = sw_db_q;
      sw_changed_d = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != sw_db_q[i]) begin
            if (cnt_q[i] == CNT_TERM) begin
               sw_db_d[i]      = sync2_q[i];
               sw_changed_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      any_changed_d = |sw_changed_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         sw_db_q       <= '0;
         sw_changed_q  <= '0;
         any_changed_q <= 1'b0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         sw_db_q       <= sw_db_d;
         sw_changed_q  <= sw_changed_d;
         any_changed_q <= any_changed_d;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign sw_db       = sw_db_q;
   assign sw_changed  = sw_changed_q;
   assign any_changed = any_changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with WIDTH=4, STABLE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_switch_debouncer;

   logic       clk;
   logic       reset;
   logic [3:0] sw_raw;
   logic [3:0] sw_db;
   logic [3:0] sw_changed;
   logic       any_changed;

   int n_checks;
   int n_pass;

   switch_debouncer #(.WIDTH(4), .STABLE_CYCLES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_raw     (sw_raw),
      .sw_db      (sw_db),
      .sw_changed (sw_changed),
      .any_changed(any_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      sw_raw = 4'hF;
      for (int k = 0; k < 3; k++) step();
      n_checks++;
      if (sw_db !== 4'h0 || sw_changed !== 4'h0 || any_changed !== 1'b0)
         $display("FAIL reset_hold: db=%h chg=%h any=%b, required 0/0/0", sw_db, sw_changed, any_changed);
      else n_pass++;
      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         logic [3:0] edb, echg;
         step();
         edb  = (k >= 6) ? 4'hF : 4'h0;
         echg = (k == 6) ? 4'hF : 4'h0;
         n_checks++;
         if (sw_db !== edb || sw_changed !== echg || any_changed !== (|echg))
            $display("FAIL reset_release edge %0d: db=%h chg=%h any=%b, required %h/%h/%b",
                     k, sw_db, sw_changed, any_changed, edb, echg, |echg);
         else n_pass++;
      end
   endtask

   task automatic test_fall();
      sw_raw = 4'h0;
      for (int k = 1; k <= 7; k++) begin
         logic [3:0] edb, echg;
         step();
         edb  = (k >= 6) ? 4'h0 : 4'hF;
         echg = (k == 6) ? 4'hF : 4'h0;
         n_checks++;
         if (sw_db !== edb || sw_changed !== echg || any_changed !== (|echg))
            $display("FAIL fall edge %0d: db=%h chg=%h any=%b, required %h/%h/%b",
                     k, sw_db, sw_changed, any_changed, edb, echg, |echg);
         else n_pass++;
      end
   endtask

   task automatic test_single_rise();
      sw_raw = 4'h1;
      for (int k = 1; k <= 7; k++) begin
         logic [3:0] edb, echg;
         step();
         edb  = (k >= 6) ? 4'h1 : 4'h0;
         echg = (k == 6) ? 4'h1 : 4'h0;
         n_checks++;
         if (sw_db !== edb || sw_changed !== echg || any_changed !== (|echg))
            $display("FAIL rise_bit0 edge %0d: db=%h chg=%h any=%b, required %h/%h/%b",
                     k, sw_db, sw_changed, any_changed, edb, echg, |echg);
         else n_pass++;
      end
      sw_raw = 4'h0;
      for (int k = 0; k < 8; k++) step();
      n_checks++;
      if (sw_db !== 4'h0) $display("FAIL rise_bit0_restore: db=%h, required 0", sw_db);
      else n_pass++;
   endtask

   task automatic test_glitch();
      sw_raw = 4'h2;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 3) sw_raw = 4'h0;
         n_checks++;
         if (sw_db !== 4'h0 || sw_changed !== 4'h0 || any_changed !== 1'b0)
            $display("FAIL glitch_bit1 edge %0d: db=%h chg=%h any=%b, required 0/0/0",
                     k, sw_db, sw_changed, any_changed);
         else n_pass++;
      end
   endtask

   task automatic test_bounce();
      int pulses;
      pulses = 0;
      for (int p = 0; p < 4; p++) begin
         sw_raw = (p % 2 == 0) ? 4'h4 : 4'h0;
         for (int k = 0; k < 2; k++) begin
            step();
            if (sw_changed[2]) pulses++;
            n_checks++;
            if (sw_db !== 4'h0) $display("FAIL bounce_phase %0d: db=%h, required 0", p, sw_db);
            else n_pass++;
         end
      end
      sw_raw = 4'h4;
      for (int k = 1; k <= 8; k++) begin
         logic [3:0] edb, echg;
         step();
         if (sw_changed[2]) pulses++;
         edb  = (k >= 6) ? 4'h4 : 4'h0;
         echg = (k == 6) ? 4'h4 : 4'h0;
         n_checks++;
         if (sw_db !== edb || sw_changed !== echg || any_changed !== (|echg))
            $display("FAIL bounce_settle edge %0d: db=%h chg=%h any=%b, required %h/%h/%b",
                     k, sw_db, sw_changed, any_changed, edb, echg, |echg);
         else n_pass++;
      end
      n_checks++;
      if (pulses != 1) $display("FAIL bounce_pulses: saw %0d, required 1", pulses);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      sw_raw = 4'hF;
      for (int k = 1; k <= 7; k++) begin
         logic [3:0] edb, echg;
         step();
         edb  = (k >= 6) ? 4'hF : 4'h4;
         echg = (k == 6) ? 4'hB : 4'h0;
         n_checks++;
         if (sw_db !== edb || sw_changed !== echg || any_changed !== (|echg))
            $display("FAIL simultaneous edge %0d: db=%h chg=%h any=%b, required %h/%h/%b",
                     k, sw_db, sw_changed, any_changed, edb, echg, |echg);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_count();
      sw_raw = 4'h1;
      for (int k = 0; k < 8; k++) step();
      n_checks++;
      if (sw_db !== 4'h1) $display("FAIL midcnt_setup: db=%h, required 1", sw_db);
      else n_pass++;
      // Bit 3 rises; after 4 edges its counter holds 2.
      sw_raw = 4'h9;
      for (int k = 0; k < 4; k++) step();
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (sw_db !== 4'h0 || sw_changed !== 4'h0 || any_changed !== 1'b0)
         $display("FAIL midcnt_async_clear: db=%h chg=%h any=%b, required 0/0/0",
                  sw_db, sw_changed, any_changed);
      else n_pass++;
      step();
      step();
      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         logic [3:0] edb, echg;
         step();
         edb  = (k >= 6) ? 4'h9 : 4'h0;
         echg = (k == 6) ? 4'h9 : 4'h0;
         n_checks++;
         if (sw_db !== edb || sw_changed !== echg || any_changed !== (|echg))
            $display("FAIL midcnt_requalify edge %0d: db=%h chg=%h any=%b, required %h/%h/%b",
                     k, sw_db, sw_changed, any_changed, edb, echg, |echg);
         else n_pass++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      sw_raw   = 4'h0;
      test_reset();
      test_fall();
      test_single_rise();
      test_glitch();
      test_bounce();
      test_simultaneous();
      test_reset_mid_count();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
